// File: rtl/alu_seq.sv
// Handshaked, registered ALU: eight single-cycle logic/arith ops plus
// iterative unsigned multiply and variable logical shifts.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [3:0]       alu_mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             busy
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready
  // (in_ready is high only in IDLE); a result is presented with out_valid in
  // DONE and held stable until the edge where out_valid && out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] M_AND  = 4'd0;
  localparam logic [3:0] M_OR   = 4'd1;
  localparam logic [3:0] M_XOR  = 4'd2;
  localparam logic [3:0] M_SHCL = 4'd3;
  localparam logic [3:0] M_SHCR = 4'd4;
  localparam logic [3:0] M_NOT  = 4'd5;
  localparam logic [3:0] M_SUB  = 4'd6;
  localparam logic [3:0] M_ADD  = 4'd7;
  localparam logic [3:0] M_MUL  = 4'd8;
  localparam logic [3:0] M_LSL  = 4'd9;
  localparam logic [3:0] M_LSR  = 4'd10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       mode_q, mode_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_out;
  logic             sc_carry;
  logic             sc_ovf;

  always_comb begin
    b_op     = (alu_mode == M_SUB) ? ~in_B : in_B;
    sum      = {1'b0, in_A} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
    sc_out   = '0;
    sc_carry = carry_in;
    sc_ovf   = 1'b0;
    case (alu_mode)
      M_AND:  sc_out = in_A & in_B;
      M_OR:   sc_out = in_A | in_B;
      M_XOR:  sc_out = in_A ^ in_B;
      M_SHCL: begin
        sc_out   = {in_A[WIDTH-2:0], carry_in};
        sc_carry = in_A[WIDTH-1];
      end
      M_SHCR: begin
        sc_out   = {carry_in, in_A[WIDTH-1:1]};
        sc_carry = in_A[0];
      end
      M_NOT:  sc_out = ~in_A;
      M_SUB, M_ADD: begin
        sc_out   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (in_A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != in_A[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // Shift-add step: {acc_q, b_q} is the running product, shifted right once per cycle.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);

  logic             load;
  logic [WIDTH-1:0] res_out;
  logic             res_carry;
  logic             res_ovf;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    res_out   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = in_A;
          b_d    = in_B;
          mode_d = alu_mode;
          acc_d  = '0;
          if (alu_mode == M_MUL) begin
            cnt_d   = SHW'(WIDTH - 1);
            state_d = S_BUSY;
          end else if (alu_mode == M_LSL || alu_mode == M_LSR) begin
            if (in_B[SHW-1:0] != '0) begin
              cnt_d   = in_B[SHW-1:0] - SHW'(1);
              state_d = S_BUSY;
            end else begin
              load      = 1'b1;
              res_out   = in_A;
              res_carry = carry_in;
              state_d   = S_DONE;
            end
          end else begin
            load      = 1'b1;
            res_out   = sc_out;
            res_carry = sc_carry;
            res_ovf   = sc_ovf;
            state_d   = S_DONE;
          end
        end
      end
      S_BUSY: begin
        case (mode_q)
          M_MUL: begin
            acc_d     = mul_sum[WIDTH:1];
            b_d       = {mul_sum[0], b_q[WIDTH-1:1]};
            res_out   = b_d;
            res_carry = |acc_d;
          end
          M_LSL: begin
            a_d       = {a_q[WIDTH-2:0], 1'b0};
            res_out   = a_d;
            res_carry = a_q[WIDTH-1];
          end
          default: begin
            a_d       = {1'b0, a_q[WIDTH-1:1]};
            res_out   = a_d;
            res_carry = a_q[0];
          end
        endcase
        if (cnt_q == '0) begin
          load    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    out_d   = load ? res_out : out_q;
    carry_d = load ? res_carry : carry_q;
    ovf_d   = load ? res_ovf : ovf_q;
    zero_d  = load ? (res_out == '0) : zero_q;
    neg_d   = load ? res_out[WIDTH-1] : neg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign out       = out_q;
  assign carry_out = carry_q;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq: a 32-bit and an 8-bit instance driven with
// directed vectors; a monitor per instance checks results, latency and busy time.
module tb_alu_seq;

  localparam logic [3:0] M_AND  = 4'd0;
  localparam logic [3:0] M_OR   = 4'd1;
  localparam logic [3:0] M_XOR  = 4'd2;
  localparam logic [3:0] M_SHCL = 4'd3;
  localparam logic [3:0] M_SHCR = 4'd4;
  localparam logic [3:0] M_NOT  = 4'd5;
  localparam logic [3:0] M_SUB  = 4'd6;
  localparam logic [3:0] M_ADD  = 4'd7;
  localparam logic [3:0] M_MUL  = 4'd8;
  localparam logic [3:0] M_LSL  = 4'd9;
  localparam logic [3:0] M_LSR  = 4'd10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, carry_in32;
  logic        carry32, zero32, neg32, ovf32, busy32;
  logic [31:0] in_a32, in_b32, out32;
  logic [3:0]  mode32;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, carry_in8;
  logic        carry8, zero8, neg8, ovf8, busy8;
  logic [7:0]  in_a8, in_b8, out8;
  logic [3:0]  mode8;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_A(in_a32), .in_B(in_b32), .alu_mode(mode32), .carry_in(carry_in32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out(out32),
    .carry_out(carry32), .zero_flag(zero32), .neg_flag(neg32), .ovf_flag(ovf32),
    .busy(busy32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_A(in_a8), .in_B(in_b8), .alu_mode(mode8), .carry_in(carry_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
    .carry_out(carry8), .zero_flag(zero8), .neg_flag(neg8), .ovf_flag(ovf8),
    .busy(busy8)
  );

  typedef struct {
    logic [31:0] out;
    logic        c;
    logic        z;
    logic        n;
    logic        o;
    int          lat;
    int          bsy;
    int          acc;
  } exp_t;

  exp_t exp_q32[$];
  exp_t exp_q8[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [31:0] o,
                       input logic c, input logic z, input logic n, input logic ov,
                       input int bc, input int now);
    check({tag, "_out"},     o,               e.out);
    check({tag, "_carry"},   32'(c),          32'(e.c));
    check({tag, "_zero"},    32'(z),          32'(e.z));
    check({tag, "_neg"},     32'(n),          32'(e.n));
    check({tag, "_ovf"},     32'(ov),         32'(e.o));
    check({tag, "_latency"}, 32'(now - e.acc), 32'(e.lat));
    check({tag, "_busy"},    32'(bc),         32'(e.bsy));
  endtask

  // driver tasks
  task automatic issue32(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] eo, input logic ec,
                         input logic eov, input int lat, input int bsy, input bit push);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready32 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready32) begin
      n_checks++;
      n_fail++;
      $display("FAIL w32_issue_timeout: in_ready=0 expected 1");
    end
    mode32 = m; in_a32 = a; in_b32 = b; carry_in32 = cin; in_valid32 = 1'b1;
    if (push) begin
      e.out = eo; e.c = ec; e.z = (eo == 32'h0); e.n = eo[31]; e.o = eov;
      e.lat = lat; e.bsy = bsy; e.acc = cyc;
      exp_q32.push_back(e);
    end
    @(posedge clk);
    #1 in_valid32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] eo, input logic ec,
                        input logic eov, input int lat, input int bsy);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready8) begin
      n_checks++;
      n_fail++;
      $display("FAIL w8_issue_timeout: in_ready=0 expected 1");
    end
    mode8 = m; in_a8 = a; in_b8 = b; carry_in8 = cin; in_valid8 = 1'b1;
    e.out = {24'h0, eo}; e.c = ec; e.z = (eo == 8'h0); e.n = eo[7]; e.o = eov;
    e.lat = lat; e.bsy = bsy; e.acc = cyc;
    exp_q8.push_back(e);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  // scoreboard monitors: compare on the first cycle of each out_valid burst
  int   bc32 = 0;
  int   bc8  = 0;
  logic pv32 = 1'b0;
  logic pv8  = 1'b0;
  exp_t e32, e8;

  always @(negedge clk) begin
    if (!rst_n) begin
      bc32 = 0;
      pv32 = 1'b0;
    end else begin
      if (busy32) bc32++;
      if (out_valid32 && !pv32) begin
        if (exp_q32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w32_unexpected_valid: out=0x%0h with no request pending", out32);
        end else begin
          e32 = exp_q32.pop_front();
          score("w32", e32, out32, carry32, zero32, neg32, ovf32, bc32, cyc);
        end
        bc32 = 0;
      end
      pv32 = out_valid32;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bc8 = 0;
      pv8 = 1'b0;
    end else begin
      if (busy8) bc8++;
      if (out_valid8 && !pv8) begin
        if (exp_q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w8_unexpected_valid: out=0x%0h with no request pending", out8);
        end else begin
          e8 = exp_q8.pop_front();
          score("w8", e8, {24'h0, out8}, carry8, zero8, neg8, ovf8, bc8, cyc);
        end
        bc8 = 0;
      end
      pv8 = out_valid8;
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; mode32 = '0; carry_in32 = 1'b0; out_ready32 = 1'b1;
    in_valid8  = 1'b0; in_a8  = '0; in_b8  = '0; mode8  = '0; carry_in8  = 1'b0; out_ready8  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst32_in_ready",  32'(in_ready32), 32'd1);
    check("rst32_out_valid", 32'(out_valid32), 32'd0);
    check("rst32_busy",      32'(busy32), 32'd0);
    check("rst32_out",       out32, 32'h0);
    check("rst32_flags",     32'({carry32, zero32, neg32, ovf32}), 32'd0);
    check("rst8_in_ready",   32'(in_ready8), 32'd1);
    check("rst8_outs",       32'({out_valid8, busy8, out8, carry8, zero8, neg8, ovf8}), 32'd0);
    rst_n = 1'b1;

    // mode, A, B, cin, exp_out, exp_carry, exp_ovf, latency, busy_cycles, push
    issue32(M_ADD,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_SUB,  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1,  0,  1'b1);
    issue32(M_MUL,  32'h00010000, 32'h00010003, 1'b0, 32'h00030000, 1'b1, 1'b0, 33, 32, 1'b1);
    issue32(M_LSL,  32'h00000003, 32'd31,       1'b0, 32'h80000000, 1'b1, 1'b0, 32, 31, 1'b1);
    issue32(M_LSL,  32'h00000003, 32'd0,        1'b1, 32'h00000003, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_LSL,  32'h12345678, 32'h00000020, 1'b0, 32'h12345678, 1'b0, 1'b0, 1,  0,  1'b1);
    issue32(M_LSR,  32'h80000001, 32'd4,        1'b1, 32'h08000000, 1'b0, 1'b0, 5,  4,  1'b1);
    issue32(M_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 1'b0, 1'b0, 1,  0,  1'b1);
    issue32(M_OR,   32'h0000FFFF, 32'h00FF0000, 1'b1, 32'h00FFFFFF, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_SHCL, 32'h80000001, 32'h0,        1'b0, 32'h00000002, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_NOT,  32'h00000000, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1,  0,  1'b1);
    issue32(4'd12,  32'h00000005, 32'h6,        1'b1, 32'h00000000, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1,  0,  1'b1);
    issue32(M_SUB,  32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1,  0,  1'b1);
    issue32(M_MUL,  32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 33, 32, 1'b1);

    // abort a multiply part-way through with reset
    issue32(M_MUL,  32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(busy32), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(in_ready32), 32'd1);
    check("abort_out_valid", 32'(out_valid32), 32'd0);
    check("abort_busy",      32'(busy32), 32'd0);
    check("abort_out",       out32, 32'h0);
    check("abort_flags",     32'({carry32, zero32, neg32, ovf32}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue32(M_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1, 0, 1'b1);

    // backpressure on the 8-bit instance
    out_ready8 = 1'b0;
    issue8(M_SHCR, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out",       {23'h0, carry8, out8}, {23'h0, 1'b1, 8'hC0});
      check("bp_in_ready",  32'(in_ready8), 32'd0);
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      in_valid8 = i[0];
      in_a8     = 8'(i * 17);
      mode8     = M_ADD;
    end
    @(negedge clk);
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drain_valid", 32'(out_valid8), 32'd0);
    check("bp_drain_ready", 32'(in_ready8), 32'd1);

    issue8(M_MUL, 8'h0F, 8'h11, 1'b0, 8'hFF, 1'b0, 1'b0, 9, 8);
    issue8(M_LSR, 8'h81, 8'h01, 1'b0, 8'h40, 1'b1, 1'b0, 2, 1);
    issue8(M_LSL, 8'h81, 8'h07, 1'b1, 8'h80, 1'b0, 1'b0, 8, 7);
    issue8(M_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1, 0);

    t = 0;
    while ((exp_q32.size() != 0 || exp_q8.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q32.size() != 0 || exp_q8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", exp_q32.size(), exp_q8.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational 32-bit ALU. It keeps the eight single-cycle operations and registers every result and flag. It adds carry-chained ADD/SUB, signed-overflow and negative flags, and three multi-cycle operations: iterative unsigned multiply, and logical shift left/right by a variable amount. It sits between the register-file read stage and writeback, with valid/ready on both sides so writeback can stall it.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- in_A, in_B  in  WIDTH  operands
- alu_mode  in  4  operation select
- carry_in  in  1  carry/shift-in bit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- carry_out  out  1  carry/shift-out bit
- zero_flag, neg_flag, ovf_flag  out  1 each  out==0; out[WIDTH-1]; signed overflow
- busy  out  1  high in BUSY

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, BUSY, DONE.
- IDLE → accept when in_valid && in_ready. At the accept edge, latch A, B, mode and carry_in.
  - Single-cycle modes go to DONE.
  - Modes 8–10 go to BUSY, except a shift with amount 0, which goes to DONE.
- Modes, all widths generic:
  - 0 AND, 1 OR, 2 XOR, 5 NOT A: carry_out=carry_in
  - 3 SHCL: out={A[W-2:0],carry_in}, carry_out=A[W-1]
  - 4 SHCR: out={carry_in,A[W-1:1]}, carry_out=A[0]
  - 6 SUB: A+~B+carry_in (carry_in=1 gives plain A−B; carry_out=1 means no borrow)
  - 7 ADD: A+B+carry_in; carry_out=bit W of the (W+1)-bit sum
  - 8 MUL: unsigned shift-add, one partial product per cycle for WIDTH cycles; out=low WIDTH bits; carry_out=1 iff high half ≠0
  - 9 LSL / 10 LSR: shift A by B[SHW-1:0], one bit per cycle, zero-fill; carry_out=last bit shifted out; amount 0 gives out=A, carry_out=carry_in
  - 11–15: reserved; out=0, carry_out=carry_in
- ovf_flag is set only for ADD/SUB: operand signs (B inverted for SUB) equal and result sign differs. It is 0 for every other mode.
- zero_flag and neg_flag are derived from the final out and registered together with it.
- DONE: out_valid=1. out, carry_out and flags hold stable until out_valid && out_ready, then the block returns to IDLE on the next cycle.
- in_ready=0 in BUSY and DONE. in_valid and operand changes in those states are ignored.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out=0, carry_out=0, all flags 0, internal counters 0.
- Asserting rst_n mid-operation aborts it immediately; no result is ever presented.
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - modes 0–7, 11–15, and shifts with amount 0: 1
  - MUL: WIDTH+1
  - LSL/LSR with amount n>0: n+1
- busy is high for exactly WIDTH cycles (MUL) or n cycles (shifts).
- Minimum issue interval is 2 cycles (accept, then DONE with out_ready=1). The next accept is possible the cycle after the drain.
- No combinational path from in_* to out*. in_ready depends only on state.

## Test plan
- ADD, WIDTH=32: A=0xFFFFFFFF, B=1, carry_in=0 → out=0, carry_out=1, zero=1, ovf=0, out_valid 1 cycle after accept.
- SUB: A=0x80000000, B=1, carry_in=1 → out=0x7FFFFFFF, carry_out=1, ovf=1, neg=0.
- MUL: A=0x00010000, B=0x00010003 → out=0x00030000, carry_out=1, busy 32 cycles, out_valid exactly 33 cycles after accept.
- LSL: A=3, B=31 → out=0x80000000, carry_out=1, latency 32. LSL with B=0, carry_in=1 → out=3, carry_out=1, latency 1.
- Backpressure, WIDTH=8: SHCR A=0x81, carry_in=1 → out=0xC0, carry_out=1. Hold out_ready=0 for 10 cycles while pulsing in_valid → outputs stable, in_ready=0, nothing accepted. Release → IDLE next cycle.
- Reset mid-MUL: drop rst_n 10 cycles after accept → all outputs at reset values immediately. After release, AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000 with latency 1.
